reg_write_arbiter: RTL and testbench

Shares the single write port of the 16x16 register file between several writeback requesters: ALU result, load data and stack-pointer update. It grants one requester per cycle using round-robin arbitration and buffers accepted writes in a small FIFO. The FIFO drains one write per cycle into the register file's write_reg/write_data/reg_write inputs. It also publishes a pending-write mask so decode can stall on read-after-write hazards.

---
 rtl/reg_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that funnels writeback requesters into a small FIFO feeding the register-file write port.
// Build option: define REG_ARB_FIXED_PRIO_EN to use fixed priority (lowest index wins) instead of round-robin.
module reg_write_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [4*N_REQ-1:0]        req_reg,
  input  logic [16*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      drain_stall,
  output logic                      reg_write,
  output logic [3:0]                write_reg,
  output logic [15:0]               write_data,
  output logic [15:0]               pending_mask,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } wr_entry_t;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("reg_write_arbiter: DEPTH must be a power of two and at least 2");
  end

  // Per-requester views of the flattened request buses
  logic [3:0]  reg_a  [N_REQ];
  logic [15:0] data_a [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign reg_a[gi]  = req_reg[4*gi +: 4];
    assign data_a[gi] = req_data[16*gi +: 16];
  end

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pop_c;
  logic             can_accept_c;
  logic             grant_any_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic [N_REQ-1:0] grant_oh_c;
  logic             fire_c;
  logic             enq_c;
  wr_entry_t        enq_entry_c;
  int unsigned      start_c;
  int unsigned      idx_v;
  logic [PTR_W-1:0] off_c;
  logic [15:0]      mask_c;

`ifdef REG_ARB_FIXED_PRIO_EN
  always_comb begin
    start_c = 0;
  end
`else
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  // Search starts just after the most recent grant
  always_comb begin
    start_c = 0;
    if (32'(last_grant_q) < (N_REQ - 1)) begin
      start_c = 32'(last_grant_q) + 1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (fire_c) begin
      last_grant_d = grant_idx_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDX_W'(N_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign pop_c        = (count_q != '0) && !drain_stall;
  assign can_accept_c = (count_q < CNT_W'(DEPTH)) || pop_c;

  // First valid requester from start_c upward, wrapping at N_REQ
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    grant_oh_c  = '0;
    idx_v       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_v = start_c + k;
      if (idx_v >= N_REQ) begin
        idx_v = idx_v - N_REQ;
      end
      if (!grant_any_c && req_valid[IDX_W'(idx_v)]) begin
        grant_any_c             = 1'b1;
        grant_idx_c             = IDX_W'(idx_v);
        grant_oh_c[IDX_W'(idx_v)] = 1'b1;
      end
    end
  end

  assign fire_c    = grant_any_c && can_accept_c && !reset;
  assign req_ready = fire_c ? grant_oh_c : '0;

  // Writes to r0 are granted but never buffered
  always_comb begin
    enq_entry_c.rd   = reg_a[grant_idx_c];
    enq_entry_c.data = data_a[grant_idx_c];
    enq_c            = fire_c && (enq_entry_c.rd != 4'd0);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_c) begin
      head_d = head_q + PTR_W'(1);
    end
    if (enq_c) begin
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq_c) begin
        mem_q[tail_q] <= enq_entry_c;
      end
    end
  end

  // Decode every occupied slot; the head stays counted while it is popped
  always_comb begin
    mask_c = '0;
    off_c  = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      off_c = PTR_W'(e) - head_q;
      if ({1'b0, off_c} < count_q) begin
        mask_c[mem_q[e].rd] = 1'b1;
      end
    end
    mask_c[0] = 1'b0;
  end

  assign pending_mask = mask_c;
  assign reg_write    = pop_c;
  assign write_reg    = (count_q != '0) ? mem_q[head_q].rd   : 4'd0;
  assign write_data   = (count_q != '0) ? mem_q[head_q].data : 16'd0;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a queue-based reference model checked every cycle plus literal checks.
module tb_reg_write_arbiter;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [11:0] req_reg;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        drain_stall;
  logic        reg_write;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic [15:0] pending_mask;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  logic [19:0] mq[$];
  logic [19:0] commits[$];
  int          lg = N_REQ - 1;

  reg_write_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .drain_stall  (drain_stall),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of {reg,data}, one grant and one pop decided per cycle
  task automatic model_check();
    int          cnt;
    logic        pop;
    logic        can;
    logic [2:0]  er;
    logic [15:0] em;
    logic [3:0]  ewr;
    logic [15:0] ewd;
    int          g;
    if (reset) begin
      check("rst_ready", req_ready, 0);
      check("rst_wr", reg_write, 0);
      check("rst_reg", write_reg, 0);
      check("rst_data", write_data, 0);
      check("rst_mask", pending_mask, 0);
      check("rst_count", fifo_count, 0);
      mq.delete();
      lg = N_REQ - 1;
      return;
    end
    cnt = mq.size();
    pop = (cnt != 0) && !drain_stall;
    can = (cnt < DEPTH) || pop;
    er  = '0;
    g   = -1;
    if (can) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
`ifdef REG_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (lg + 1 + k) % N_REQ;
`endif
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    em = '0;
    foreach (mq[i]) em[mq[i][19:16]] = 1'b1;
    em[0] = 1'b0;
    ewr = (cnt != 0) ? mq[0][19:16] : 4'd0;
    ewd = (cnt != 0) ? mq[0][15:0] : 16'd0;
    check("m_ready", req_ready, er);
    check("m_wr", reg_write, pop);
    check("m_reg", write_reg, ewr);
    check("m_data", write_data, ewd);
    check("m_mask", pending_mask, em);
    check("m_count", fifo_count, cnt);
    if (reg_write === 1'b1) commits.push_back({write_reg, write_data});
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      lg = g;
      if (req_reg[4*g +: 4] != 4'd0) mq.push_back({req_reg[4*g +: 4], req_data[16*g +: 16]});
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && fifo_count != 0; i++) cyc();
    check("drain_empty", fifo_count, 0);
  endtask

  logic [2:0] exp_g [6];
  int         m;

  initial begin
    reset       = 1'b1;
    req_valid   = 3'b111;
    req_reg     = {4'd3, 4'd2, 4'd1};
    req_data    = 48'h3333_2222_1111;
    drain_stall = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ready", req_ready, 0);
    check("reset_count", fifo_count, 0);
    check("reset_wr", reg_write, 0);
    cyc();
    reset     = 1'b0;
    req_valid = 3'b000;
    #1;
    check("post_reset_mask", pending_mask, 0);
    cyc();

    // single ALU write to r3
    req_valid = 3'b001;
    req_reg   = {4'd0, 4'd0, 4'd3};
    req_data  = {16'h0, 16'h0, 16'h1234};
    #1;
    check("s1_ready", req_ready, 3'b001);
    cyc();
    req_valid = 3'b000;
    #1;
    check("s1_wr", reg_write, 1);
    check("s1_reg", write_reg, 4'd3);
    check("s1_data", write_data, 16'h1234);
    check("s1_mask", pending_mask, 16'h0008);
    cyc();
    check("s1_mask_after", pending_mask, 16'h0000);
    check("s1_wr_after", reg_write, 0);
    cyc();

    // all three requesters continuously valid
`ifdef REG_ARB_FIXED_PRIO_EN
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`endif
    req_valid = 3'b111;
    req_reg   = {4'd3, 4'd2, 4'd1};
    req_data  = 48'hC003_B002_A001;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("s2_grant%0d", i), req_ready, exp_g[i]);
      cyc();
    end
    req_valid = 3'b000;
    drain();

    // fill under stall, fifth write waits until the first pop
    drain_stall = 1'b1;
    req_valid   = 3'b010;
    for (int r = 4; r < 8; r++) begin
      req_reg[7:4]   = 4'(r);
      req_data[31:16] = 16'hA000 + 16'(r);
      #1;
      check($sformatf("s3_ready_r%0d", r), req_ready, 3'b010);
      cyc();
    end
    req_reg[7:4]    = 4'd8;
    req_data[31:16] = 16'hA008;
    #1;
    check("s3_full_ready", req_ready, 3'b000);
    check("s3_full_count", fifo_count, 3'd4);
    check("s3_full_mask", pending_mask, 16'h00F0);
    cyc();
    m = commits.size();
    drain_stall = 1'b0;
    #1;
    check("s3_pop_ready", req_ready, 3'b010);
    check("s3_pop_wr", reg_write, 1);
    check("s3_pop_reg", write_reg, 4'd4);
    cyc();
    req_valid = 3'b000;
    drain();
    check("s3_ncommits", commits.size() - m, 5);
    for (int i = 0; i < 5 && (m + i) < commits.size(); i++)
      check($sformatf("s3_commit%0d", i), commits[m+i], {4'(4 + i), 16'hA004 + 16'(i)});

    // write to r0 is granted and dropped
    m = commits.size();
    req_valid = 3'b001;
    req_reg   = 12'h000;
    req_data  = {32'h0, 16'hFFFF};
    #1;
    check("s4_ready", req_ready, 3'b001);
    cyc();
    req_valid = 3'b000;
    #1;
    check("s4_count", fifo_count, 0);
    check("s4_wr", reg_write, 0);
    check("s4_mask", pending_mask, 0);
    cyc();
    check("s4_ncommits", commits.size() - m, 0);

    // reset discards buffered writes
    drain_stall = 1'b1;
    req_valid   = 3'b100;
    req_reg     = {4'd10, 8'h00};
    req_data    = {16'h0BAD, 32'h0};
    #1;
    check("s5_ready_a", req_ready, 3'b100);
    cyc();
    req_reg  = {4'd11, 8'h00};
    req_data = {16'h0BEE, 32'h0};
    #1;
    check("s5_ready_b", req_ready, 3'b100);
    cyc();
    req_valid = 3'b000;
    #1;
    check("s5_count", fifo_count, 3'd2);
    check("s5_mask", pending_mask, 16'h0C00);
    m = commits.size();
    reset       = 1'b1;
    drain_stall = 1'b0;
    #1;
    check("s5_rst_count", fifo_count, 0);
    check("s5_rst_wr", reg_write, 0);
    check("s5_rst_mask", pending_mask, 0);
    cyc();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) cyc();
    check("s5_no_stale", commits.size() - m, 0);
    req_valid = 3'b111;
    req_reg   = {4'd3, 4'd2, 4'd1};
    req_data  = 48'hC003_B002_A001;
    #1;
    check("s5_first_prio", req_ready, 3'b001);
    cyc();
    req_valid = 3'b000;
    drain();

    // two writes to r9 commit in grant order
    m = commits.size();
    drain_stall = 1'b1;
    req_valid   = 3'b001;
    req_reg     = {8'h00, 4'd9};
    req_data    = {32'h0, 16'h0001};
    cyc();
    req_data = {32'h0, 16'h0002};
    #1;
    check("s6_ready_b", req_ready, 3'b001);
    cyc();
    req_valid   = 3'b000;
    drain_stall = 1'b0;
    #1;
    check("s6_mask_a", pending_mask, 16'h0200);
    check("s6_data_a", write_data, 16'h0001);
    cyc();
    check("s6_mask_b", pending_mask, 16'h0200);
    check("s6_data_b", write_data, 16'h0002);
    check("s6_wr_b", reg_write, 1);
    cyc();
    check("s6_mask_c", pending_mask, 16'h0000);
    check("s6_count_c", fifo_count, 0);
    check("s6_ncommits", commits.size() - m, 2);
    if (commits.size() >= m + 2) begin
      check("s6_commit0", commits[m], {4'd9, 16'h0001});
      check("s6_commit1", commits[m+1], {4'd9, 16'h0002});
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
